// File: rtl/pc_gen_unit.sv
// Fetch PC generator: BOOT/RUN sequencing, imem req/ack, prioritised redirects with a held redirect.
// Optional direct-mapped BTB next-PC prediction enabled by defining PC_BTB_EN.
module pc_gen_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                BTB_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              fetch_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              chip_enable,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken
);
    localparam int                OFF   = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN = ~(ADDR_W'(INST_BYTES - 1));

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state;
    logic              pend_v;
    logic [ADDR_W-1:0] pend;
    logic [ADDR_W-1:0] next_seq;
    logic              hit;

`ifdef PC_BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - OFF - IDX_W;

    logic [BTB_DEPTH-1:0] btb_vld;
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];
    logic [IDX_W-1:0]     rd_idx, wr_idx;
    logic [TAG_W-1:0]     rd_tag, wr_tag;
    logic                 unused_upd_lo;

    assign rd_idx        = pc[OFF +: IDX_W];
    assign rd_tag        = pc[ADDR_W-1 -: TAG_W];
    assign wr_idx        = upd_pc[OFF +: IDX_W];
    assign wr_tag        = upd_pc[ADDR_W-1 -: TAG_W];
    assign unused_upd_lo = ^(upd_pc & ~ALIGN);
    assign hit           = btb_vld[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign next_seq      = hit ? btb_tgt[rd_idx] : pc + STEP;

    // Nonblocking writes mean a same-edge update is invisible to this edge's read.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_vld <= '0;
        end else if (upd_valid) begin
            if (upd_taken)
                btb_vld[wr_idx] <= 1'b1;
            else if (btb_vld[wr_idx] && btb_tag[wr_idx] == wr_tag)
                btb_vld[wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[wr_idx] <= wr_tag;
            btb_tgt[wr_idx] <= upd_target & ALIGN;
        end
    end
`else
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign hit        = 1'b0;
    assign next_seq   = pc + STEP;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            chip_enable <= 1'b0;
            pred_taken  <= 1'b0;
            pend_v      <= 1'b0;
            pend        <= '0;
        end else begin
            pred_taken <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    chip_enable <= 1'b1;
                end
                default: begin
                    chip_enable <= 1'b1;
                    if (exc_valid) begin
                        pc     <= exc_pc & ALIGN;
                        pend_v <= 1'b0;
                    end else if (stall_if) begin
                        // Latest branch seen during a stall wins.
                        if (br_taken) begin
                            pend_v <= 1'b1;
                            pend   <= br_target & ALIGN;
                        end
                    end else if (br_taken) begin
                        pc     <= br_target & ALIGN;
                        pend_v <= 1'b0;
                    end else if (pend_v) begin
                        pc     <= pend;
                        pend_v <= 1'b0;
                    end else if (fetch_ack) begin
                        pc         <= next_seq;
                        pred_taken <= hit;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed vector table, random run vs. reference model, corner sequences.
module tb_pc_gen_unit;
    logic        clk = 1'b0;
    logic        rst, stall_if, exc_valid, br_taken, fetch_ack;
    logic [31:0] exc_pc, br_target;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic [31:0] pc;
    logic        chip_enable, pred_taken;

    logic        r8, br8, ack8, z1;
    logic [7:0]  bt8, z8, pc8;
    logic        ce8, pr8;

    int checks = 0;
    int errors = 0;

`ifdef PC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_gen_unit #(.ADDR_W(32), .INST_BYTES(4), .RESET_PC(32'h100), .BTB_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .exc_valid(exc_valid), .exc_pc(exc_pc),
        .br_taken(br_taken), .br_target(br_target), .fetch_ack(fetch_ack), .pc(pc),
        .chip_enable(chip_enable), .pred_taken(pred_taken), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
    );

    pc_gen_unit #(.ADDR_W(8), .INST_BYTES(4), .RESET_PC(8'h00), .BTB_DEPTH(16)) dut8 (
        .clk(clk), .rst(r8), .stall_if(z1), .exc_valid(z1), .exc_pc(z8),
        .br_taken(br8), .br_target(bt8), .fetch_ack(ack8), .pc(pc8),
        .chip_enable(ce8), .pred_taken(pr8), .upd_valid(z1),
        .upd_pc(z8), .upd_target(z8), .upd_taken(z1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic rst, stall, exc; logic [31:0] epc;
        logic br; logic [31:0] bt; logic ack;
        logic [31:0] xpc; logic xce;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(logic r, logic s, logic e, logic [31:0] ep, logic b,
                                logic [31:0] t, logic a, logic [31:0] xp, logic xc);
        vec_t v;
        v.rst = r; v.stall = s; v.exc = e; v.epc = ep; v.br = b; v.bt = t; v.ack = a;
        v.xpc = xp; v.xce = xc;
        return v;
    endfunction

    // Reference model state
    logic [31:0] m_pc, m_pend;
    logic        m_ce, m_boot, m_pv, m_pred;
    logic        m_bv [16];
    logic [31:0] m_bpc [16], m_bt [16];

    function automatic logic [31:0] al(logic [31:0] x);
        return x & ~32'h3;
    endfunction

    task automatic model_step();
        int i, ui;
        logic h;
        logic [31:0] seq;
        if (rst) begin
            m_pc = 32'h100; m_ce = 0; m_boot = 1; m_pv = 0; m_pred = 0;
            for (int k = 0; k < 16; k++) m_bv[k] = 0;
            return;
        end
        i   = int'((m_pc >> 2) % 16);
        h   = BTB && m_bv[i] && m_bpc[i] == al(m_pc);
        seq = h ? m_bt[i] : m_pc + 32'd4;
        if (BTB && upd_valid) begin
            ui = int'((al(upd_pc) >> 2) % 16);
            if (upd_taken) begin
                m_bv[ui] = 1; m_bpc[ui] = al(upd_pc); m_bt[ui] = al(upd_target);
            end else if (m_bv[ui] && m_bpc[ui] == al(upd_pc)) begin
                m_bv[ui] = 0;
            end
        end
        m_pred = 0;
        if (m_boot) begin
            m_boot = 0; m_ce = 1;
        end else if (exc_valid) begin
            m_pc = al(exc_pc); m_pv = 0;
        end else if (stall_if) begin
            if (br_taken) begin m_pv = 1; m_pend = al(br_target); end
        end else if (br_taken) begin
            m_pc = al(br_target); m_pv = 0;
        end else if (m_pv) begin
            m_pc = m_pend; m_pv = 0;
        end else if (fetch_ack) begin
            m_pc = seq; m_pred = h;
        end
    endtask

    task automatic idle();
        rst = 0; stall_if = 0; exc_valid = 0; br_taken = 0; fetch_ack = 0;
        exc_pc = '0; br_target = '0; upd_valid = 0; upd_taken = 0; upd_pc = '0; upd_target = '0;
    endtask

    initial begin
        idle();
        rst = 1; r8 = 1; br8 = 0; ack8 = 0; bt8 = '0; z1 = 0; z8 = '0;

        // reset, boot, sequential (T1)
        vt.push_back(mk(1,0,0,0,   0,0,      1, 32'h100, 0));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h100, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h104, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h108, 1));
        // ack held low (T2)
        vt.push_back(mk(0,0,0,0,   1,32'h20, 0, 32'h020, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      0, 32'h020, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      0, 32'h020, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      0, 32'h020, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h024, 1));
        // branches during stall, newest wins (T3)
        vt.push_back(mk(0,1,0,0,   1,32'h400,0, 32'h024, 1));
        vt.push_back(mk(0,1,0,0,   1,32'h500,1, 32'h024, 1));
        vt.push_back(mk(0,1,0,0,   0,0,      0, 32'h024, 1));
        vt.push_back(mk(0,1,0,0,   0,0,      1, 32'h024, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h500, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h504, 1));
        // exception beats stall and branch, kills pending (T4)
        vt.push_back(mk(0,1,1,32'h80,1,32'h900,1,32'h080, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h084, 1));
        vt.push_back(mk(0,1,0,0,   1,32'h600,0, 32'h084, 1));
        vt.push_back(mk(0,0,1,32'h33,0,0,    1, 32'h030, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h034, 1));
        // mid-run reset
        vt.push_back(mk(1,0,0,0,   0,0,      1, 32'h100, 0));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h100, 1));
        vt.push_back(mk(0,0,0,0,   0,0,      1, 32'h104, 1));

        for (int n = 0; n < vt.size(); n++) begin
            rst = vt[n].rst; stall_if = vt[n].stall; exc_valid = vt[n].exc; exc_pc = vt[n].epc;
            br_taken = vt[n].br; br_target = vt[n].bt; fetch_ack = vt[n].ack;
            tick();
            chk($sformatf("vec%0d_pc", n), pc, vt[n].xpc);
            chk($sformatf("vec%0d_ce", n), {31'b0, chip_enable}, {31'b0, vt[n].xce});
            chk($sformatf("vec%0d_pred", n), {31'b0, pred_taken}, 32'd0);
        end

        // Random run against the reference model
        for (int n = 0; n < 2000; n++) begin
            rst        = (n == 0) || ($urandom_range(63) == 0);
            stall_if   = ($urandom_range(3) == 0);
            exc_valid  = ($urandom_range(15) == 0);
            exc_pc     = $urandom;
            br_taken   = ($urandom_range(5) == 0);
            br_target  = $urandom_range(255) << 2 | $urandom_range(3);
            fetch_ack  = ($urandom_range(3) != 0);
            upd_valid  = ($urandom_range(2) == 0);
            upd_taken  = ($urandom_range(2) != 0);
            upd_pc     = $urandom_range(1) ? m_pc : ($urandom_range(255) << 2);
            upd_target = $urandom_range(1023);
            model_step();
            tick();
            chk("rand_pc", pc, m_pc);
            chk("rand_ce", {31'b0, chip_enable}, {31'b0, m_ce});
            chk("rand_pred", {31'b0, pred_taken}, {31'b0, m_pred});
        end
        idle();

        // 8-bit wrap and target alignment (T5)
        r8 = 1; tick();
        r8 = 0; tick();
        chk("w8_boot_pc", {24'b0, pc8}, 32'h00);
        chk("w8_run_ce", {31'b0, ce8}, 32'd1);
        br8 = 1; bt8 = 8'hFC; tick();
        chk("w8_br_pc", {24'b0, pc8}, 32'hFC);
        br8 = 0; ack8 = 1; tick();
        chk("w8_wrap_pc", {24'b0, pc8}, 32'h00);
        br8 = 1; bt8 = 8'h13; ack8 = 0; tick();
        chk("w8_align_pc", {24'b0, pc8}, 32'h10);
        br8 = 0; ack8 = 1; tick();
        chk("w8_seq_pc", {24'b0, pc8}, 32'h14);

`ifdef PC_BTB_EN
        // BTB install, predicted fetch, invalidate (T6)
        rst = 1; tick();
        rst = 0; tick();
        br_taken = 1; br_target = 32'h40;
        upd_valid = 1; upd_taken = 1; upd_pc = 32'h40; upd_target = 32'h200; tick();
        chk("btb_br_pc", pc, 32'h40);
        idle(); fetch_ack = 1; tick();
        chk("btb_hit_pc", pc, 32'h200);
        chk("btb_hit_pred", {31'b0, pred_taken}, 32'd1);
        idle(); br_taken = 1; br_target = 32'h40;
        upd_valid = 1; upd_taken = 0; upd_pc = 32'h40; tick();
        chk("btb_inv_pred", {31'b0, pred_taken}, 32'd0);
        idle(); fetch_ack = 1; tick();
        chk("btb_miss_pc", pc, 32'h44);
        chk("btb_miss_pred", {31'b0, pred_taken}, 32'd0);
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
